// File: rtl/frame_arb_pkg.sv
// frame_arb_pkg: shared FSM state type and arbitration mode constants
package frame_arb_pkg;
   typedef enum logic [1:0] {IDLE, GRANT, BUSY, TURN} state_t;
   localparam int RR = 1;
   localparam int FIXED = 0;
endpackage

// File: rtl/frame_arbiter_rr_picker.sv
// rr_picker: first set request at or above pointer, wrapping to 0
module rr_picker #(
   parameter int N_CH = 4,
   parameter int PW = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [PW-1:0]   pointer,
   output logic            valid,
   output logic [PW-1:0]   winner
);
   always_comb begin
      valid = |req;
      winner = '0;
      for (int i = N_CH - 1; i >= 0; i--)
         if (req[(int'(pointer) + i) % N_CH]) winner = PW'((int'(pointer) + i) % N_CH);
   end
endmodule

// File: rtl/frame_arbiter.sv
// frame_arbiter: N-channel bus arbiter with grant timeout, frame length limit and protocol checks
module frame_arbiter
   import frame_arb_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int GNT_TIMEOUT = 8,
   parameter int MAX_FRAME = 16,
   parameter int RR_MODE = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_CH-1:0]         req,
   input  logic [N_CH-1:0]         frame,
   output logic [N_CH-1:0]         grant,
   output logic [N_CH-1:0]         aquired,
   output logic [$clog2(N_CH)-1:0] owner,
   output logic                    busy,
   output logic                    err_timeout,
   output logic                    err_len,
   output logic                    err_proto
);
   localparam int PW = $clog2(N_CH);
   localparam int TW = $clog2(GNT_TIMEOUT + 1);
   localparam int FW = MAX_FRAME > 0 ? $clog2(MAX_FRAME + 1) : 1;
   state_t state, state_n;
   logic [PW-1:0] ptr, ptr_n, owner_n, win;
   logic [TW-1:0] tcnt, tcnt_n;
   logic [FW-1:0] fcnt, fcnt_n;
   logic [N_CH-1:0] own_oh, nxt_oh, grant_n, aquired_n;
   logic vld, et_n, el_n, ep_n;
   rr_picker #(.N_CH(N_CH)) u_pick (
      .req(req),
      .pointer(RR_MODE == RR ? ptr : '0),
      .valid(vld),
      .winner(win)
   );
   assign own_oh = N_CH'(1) << owner;
   assign nxt_oh = N_CH'(1) << owner_n;
   always_comb begin
      state_n = state;
      ptr_n = ptr;
      owner_n = owner;
      tcnt_n = tcnt;
      fcnt_n = fcnt;
      et_n = 1'b0;
      el_n = 1'b0;
      ep_n = |(frame & (state == IDLE ? '1 : ~own_oh));
      case (state)
         IDLE: if (vld) begin
            state_n = GRANT;
            owner_n = win;
            tcnt_n = '0;
         end
         GRANT: if (frame[owner]) begin
            state_n = BUSY;
            fcnt_n = '0;
         end else if (!req[owner]) state_n = TURN;
         else if (tcnt == TW'(GNT_TIMEOUT - 1)) begin
            state_n = TURN;
            et_n = 1'b1;
         end else tcnt_n = tcnt + TW'(1);
         BUSY: if (!frame[owner]) state_n = TURN;
         else if (MAX_FRAME != 0 && fcnt == FW'(MAX_FRAME - 1)) begin
            state_n = TURN;
            el_n = 1'b1;
         end else if (fcnt != '1) fcnt_n = fcnt + FW'(1);
         TURN: begin
            state_n = IDLE;
            ptr_n = owner == PW'(N_CH - 1) ? '0 : owner + PW'(1);
            owner_n = '0;
         end
         default: state_n = IDLE;
      endcase
      grant_n = (state_n == GRANT || state_n == BUSY) ? nxt_oh : '0;
      aquired_n = state_n == BUSY ? nxt_oh : '0;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr <= '0;
         owner <= '0;
         tcnt <= '0;
         fcnt <= '0;
         grant <= '0;
         aquired <= '0;
         busy <= 1'b0;
         err_timeout <= 1'b0;
         err_len <= 1'b0;
         err_proto <= 1'b0;
      end else begin
         state <= state_n;
         ptr <= ptr_n;
         owner <= owner_n;
         tcnt <= tcnt_n;
         fcnt <= fcnt_n;
         grant <= grant_n;
         aquired <= aquired_n;
         busy <= state_n != IDLE;
         err_timeout <= et_n;
         err_len <= el_n;
         err_proto <= ep_n;
      end
   end
endmodule

// File: tb/tb_frame_arbiter.sv
// tb_frame_arbiter: directed checks of a round-robin and a fixed-priority arbiter
module tb_frame_arbiter;
   logic clk = 1'b0;
   logic rst_n, rst2_n;
   logic [3:0] req, frame, grant, aquired, req2, frame2, grant2, aquired2;
   logic [1:0] owner, owner2;
   logic busy, err_timeout, err_len, err_proto, busy2, et2, el2, ep2;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   frame_arbiter #(.N_CH(4), .GNT_TIMEOUT(8), .MAX_FRAME(16), .RR_MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .req(req), .frame(frame), .grant(grant), .aquired(aquired),
      .owner(owner), .busy(busy), .err_timeout(err_timeout), .err_len(err_len), .err_proto(err_proto)
   );
   frame_arbiter #(.N_CH(4), .GNT_TIMEOUT(8), .MAX_FRAME(16), .RR_MODE(0)) u_fix (
      .clk(clk), .rst_n(rst2_n), .req(req2), .frame(frame2), .grant(grant2), .aquired(aquired2),
      .owner(owner2), .busy(busy2), .err_timeout(et2), .err_len(el2), .err_proto(ep2)
   );
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic expect_o(input string tag, input logic [3:0] g, input logic [3:0] a,
                           input logic [1:0] ow, input logic b, input logic [2:0] e);
      logic [13:0] obs, exp;
      obs = {grant, aquired, owner, busy, err_timeout, err_len, err_proto};
      exp = {g, a, ow, b, e};
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %b expected %b (grant,aquired,owner,busy,et,el,ep)", tag, obs, exp);
      end
   endtask
   task automatic expect_fix(input string tag, input logic [3:0] g, input logic [3:0] a);
      checks++;
      assert ({grant2, aquired2} === {g, a})
      else begin
         errors++;
         $error("FAIL %s observed %b/%b expected %b/%b", tag, grant2, aquired2, g, a);
      end
   endtask
   initial begin
      rst_n = 1'b0; rst2_n = 1'b0;
      req = '0; frame = '0; req2 = '0; frame2 = '0;
      step(2);
      expect_o("reset", 4'b0000, 4'b0000, 2'd0, 1'b0, 3'b000);
      rst_n = 1'b1; req = 4'b0101;
      step();
      expect_o("arb0", 4'b0001, 4'b0000, 2'd0, 1'b1, 3'b000);
      frame = 4'b0001;
      step();
      expect_o("busy0", 4'b0001, 4'b0001, 2'd0, 1'b1, 3'b000);
      step(2);
      frame = '0;
      step();
      expect_o("turn0", 4'b0000, 4'b0000, 2'd0, 1'b1, 3'b000);
      step();
      expect_o("idle0", 4'b0000, 4'b0000, 2'd0, 1'b0, 3'b000);
      step();
      expect_o("arb2", 4'b0100, 4'b0000, 2'd2, 1'b1, 3'b000);
      step(7);
      expect_o("wait2", 4'b0100, 4'b0000, 2'd2, 1'b1, 3'b000);
      step();
      expect_o("timeout", 4'b0000, 4'b0000, 2'd2, 1'b1, 3'b100);
      req = '0;
      step();
      expect_o("idle1", 4'b0000, 4'b0000, 2'd0, 1'b0, 3'b000);
      req = 4'b0010;
      step();
      expect_o("arb1", 4'b0010, 4'b0000, 2'd1, 1'b1, 3'b000);
      req = '0;
      step();
      expect_o("withdraw", 4'b0000, 4'b0000, 2'd1, 1'b1, 3'b000);
      step();
      req = 4'b0010;
      step();
      expect_o("arb1b", 4'b0010, 4'b0000, 2'd1, 1'b1, 3'b000);
      frame = 4'b0010;
      step();
      expect_o("busy1", 4'b0010, 4'b0010, 2'd1, 1'b1, 3'b000);
      step(15);
      expect_o("len_hold", 4'b0010, 4'b0010, 2'd1, 1'b1, 3'b000);
      step();
      expect_o("len", 4'b0000, 4'b0000, 2'd1, 1'b1, 3'b010);
      req = '0;
      step();
      expect_o("idle2", 4'b0000, 4'b0000, 2'd0, 1'b0, 3'b000);
      step();
      expect_o("proto_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 3'b001);
      frame = '0; req = 4'b1000;
      step();
      expect_o("arb3", 4'b1000, 4'b0000, 2'd3, 1'b1, 3'b000);
      frame = 4'b1001;
      step();
      expect_o("proto1", 4'b1000, 4'b1000, 2'd3, 1'b1, 3'b001);
      step();
      expect_o("proto2", 4'b1000, 4'b1000, 2'd3, 1'b1, 3'b001);
      frame = 4'b1000;
      step();
      expect_o("proto_end", 4'b1000, 4'b1000, 2'd3, 1'b1, 3'b000);
      rst_n = 1'b0;
      step();
      expect_o("rst_busy", 4'b0000, 4'b0000, 2'd0, 1'b0, 3'b000);
      rst_n = 1'b1; req = 4'b1111; frame = '0;
      step();
      expect_o("arb_rst", 4'b0001, 4'b0000, 2'd0, 1'b1, 3'b000);
      req = 4'b1011;
      step();
      expect_o("no_preempt", 4'b0001, 4'b0000, 2'd0, 1'b1, 3'b000);
      frame = 4'b0001; req = 4'b1110;
      step();
      expect_o("busy_own0", 4'b0001, 4'b0001, 2'd0, 1'b1, 3'b000);
      frame = '0;
      step(2);
      step();
      expect_o("rr_next", 4'b0010, 4'b0000, 2'd1, 1'b1, 3'b000);
      step(7);
      frame = 4'b0010;
      step();
      expect_o("frame_vs_tmo", 4'b0010, 4'b0010, 2'd1, 1'b1, 3'b000);
      step(15);
      frame = '0;
      step();
      expect_o("fall_vs_len", 4'b0000, 4'b0000, 2'd1, 1'b1, 3'b000);
      req = '0;
      step();
      rst2_n = 1'b1; req2 = 4'b1110;
      step();
      expect_fix("fix0", 4'b0010, 4'b0000);
      frame2 = 4'b0010;
      step();
      expect_fix("fix_busy", 4'b0010, 4'b0010);
      frame2 = '0;
      step();
      expect_fix("fix_turn", 4'b0000, 4'b0000);
      step(2);
      expect_fix("fix1", 4'b0010, 4'b0000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/frame_arbiter.md
FRAME_ARBITER -- requirements
Module: frame_arbiter

Interface
REQ-001 Parameter N_CH, default 4, number of requesting channels (2..16).
REQ-002 Parameter GNT_TIMEOUT, default 8, cycles granted channel has to raise frame (1..255).
REQ-003 Parameter MAX_FRAME, default 16, max frame cycles; 0 = unlimited.
REQ-004 Parameter RR_MODE, default 1: 1 = round-robin, 0 = fixed priority (channel 0 highest).
REQ-005 clk  in  1  sole clock, all logic on posedge clk.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 req  in  N_CH  per-channel bus request.
REQ-008 frame  in  N_CH  per-channel frame, driven by the channel while it transfers.
REQ-009 grant  out  N_CH  one-hot-or-zero bus grant.
REQ-010 aquired  out  N_CH  one-hot-or-zero; granted channel currently holds the bus with frame active.
REQ-011 owner  out  $clog2(N_CH)  index of current grantee; 0 when idle.
REQ-012 busy  out  1  arbiter not in IDLE.
REQ-013 err_timeout, err_len, err_proto  out  1 each  one-cycle error pulses.

Function
REQ-014 FSM states: IDLE, GRANT, BUSY, TURN; all outputs registered.
REQ-015 IDLE: any req bit set at edge t -> winner picked, grant[w]=1, owner=w, state GRANT from t+1 (1-cycle latency).
REQ-016 RR_MODE=1: winner = first set req at or above pointer, wrapping N_CH-1 -> 0; pointer resets to 0.
REQ-017 RR_MODE=0: winner = lowest-index set req; pointer ignored.
REQ-018 GRANT: frame[w]=1 -> BUSY, aquired[w]=1 next cycle; grant held.
REQ-019 GRANT: req[w]=0 and frame[w]=0 -> TURN (request withdrawn, no error).
REQ-020 GRANT: GNT_TIMEOUT cycles elapsed without frame[w] -> TURN, err_timeout pulses once.
REQ-021 BUSY: frame[w] deasserts -> TURN; grant and aquired drop next cycle.
REQ-022 BUSY: MAX_FRAME!=0 and frame held MAX_FRAME cycles -> TURN forced, err_len pulses once.
REQ-023 TURN: exactly one cycle; grant, aquired all zero; pointer := (w+1) mod N_CH; -> IDLE.
REQ-024 frame[i]=1 for any i != w while busy, or any frame bit in IDLE: err_proto pulses each such cycle; no state effect.
REQ-025 Timeout counter width $clog2(GNT_TIMEOUT+1), frame counter width $clog2(MAX_FRAME+1); both clear on entry to GRANT/BUSY, never wrap.
REQ-026 Simultaneous frame[w] rise and timeout expiry in GRANT: frame wins, no err_timeout.
REQ-027 Simultaneous frame[w] fall and MAX_FRAME reached: normal release, no err_len.
REQ-028 req changes by non-owners never disturb a grant in progress (no preemption except REQ-022).
REQ-029 At most one grant bit and one aquired bit set in any cycle.

Reset
REQ-030 rst_n=0 at a posedge: state IDLE, grant=0, aquired=0, owner=0, busy=0, all err=0, pointer=0, counters=0.
REQ-031 Reset mid-GRANT or mid-BUSY aborts ownership the next edge; no error pulses issued.
REQ-032 First arbitration possible on the edge after rst_n returns high.

Structure
REQ-033 Package frame_arb_pkg holds state enum (IDLE, GRANT, BUSY, TURN) and mode constants RR/FIXED.
REQ-034 One sub-module rr_picker: combinational, inputs req and pointer, outputs valid and winner index; instantiated once.
REQ-035 Error outputs suitable for SVA binding; no internal assertion logic required in RTL.

Verification (N_CH=4, GNT_TIMEOUT=8, MAX_FRAME=16, RR_MODE=1)
REQ-036 req=4'b0101 from reset -> grant=0001 one cycle later; after ch0 frame 3 cycles and TURN, grant=0100.
REQ-037 Ch2 granted, frame never rises -> err_timeout pulse 8 cycles after grant, grant clears, TURN then IDLE.
REQ-038 Ch1 frame held 20 cycles -> err_len at frame cycle 16, grant/aquired clear next cycle.
REQ-039 Ch3 owns bus, ch0 drives frame=1 -> err_proto each such cycle, grant stays 1000.
REQ-040 rst_n=0 during BUSY -> all outputs zero next edge, pointer 0; req=1111 after reset -> grant=0001.
REQ-041 RR_MODE=0, req=1110 held continuously -> grant always 0010 after each TURN.
